// File: rtl/fcpu_pkg.sv
// Shared CPU widths, opcode encoding and the CDB response record.
// Also provides the memory-unit helper that sorts opcodes into load/store/output.
package fcpu_pkg;

  localparam int INSTR_W  = 5;
  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 16;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef enum logic [INSTR_W-1:0] {
    I_NOP     = 5'd0,
    I_ADD     = 5'd1,
    I_SUB     = 5'd2,
    I_AND     = 5'd3,
    I_OR      = 5'd4,
    I_LOAD    = 5'd5,
    I_LOADB   = 5'd6,
    I_LOADTB  = 5'd7,
    I_STORE   = 5'd8,
    I_STOREB  = 5'd9,
    I_STORER  = 5'd10,
    I_STORET  = 5'd11,
    I_STORETB = 5'd12,
    I_OUTPUT  = 5'd13,
    I_JMP     = 5'd14,
    I_HALT    = 5'd15
  } opcode_t;

  // Rob id sits in the upper bits so the packed struct matches the CDB layout.
  typedef struct packed {
    logic [RSV_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   data;
  } cdb_resp_t;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_LOAD   = 2'd1,
    OP_STORE  = 2'd2,
    OP_OUTPUT = 2'd3
  } mem_op_class_t;

  function automatic mem_op_class_t classify_mem_op(input logic [INSTR_W-1:0] op);
    mem_op_class_t cls;
    cls = OP_NONE;
    case (op)
      I_LOAD, I_LOADB, I_LOADTB:                        cls = OP_LOAD;
      I_STORE, I_STOREB, I_STORER, I_STORET, I_STORETB: cls = OP_STORE;
      I_OUTPUT:                                         cls = OP_OUTPUT;
      default:                                          cls = OP_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port data memory: write at the clock edge, registered read data.
// Contents are deliberately left unreset so the array maps onto block RAM.
module data_ram #(
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/fifo.sv
// Small synchronous FIFO with a combinational head; push and pop may coincide
// even when full, in which case occupancy is unchanged.
module fifo #(
  parameter int WIDTH        = 8,
  parameter int FIFO_DEPTH_W = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  empty,
  output logic                  full,
  output logic [FIFO_DEPTH_W:0] count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_W;
  localparam logic [FIFO_DEPTH_W:0] FULL_COUNT = (FIFO_DEPTH_W + 1)'(DEPTH);

  logic [WIDTH-1:0]        mem_reg [DEPTH];
  logic [FIFO_DEPTH_W-1:0] rd_ptr_reg;
  logic [FIFO_DEPTH_W-1:0] wr_ptr_reg;
  logic [FIFO_DEPTH_W:0]   count_reg;
  logic [FIFO_DEPTH_W:0]   count_next;
  logic                    do_push;
  logic                    do_pop;

  assign do_pop  = pop & (count_reg != '0);
  assign do_push = push & ((count_reg != FULL_COUNT) | do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (FIFO_DEPTH_W + 1)'(1);
      2'b01:   count_next = count_reg - (FIFO_DEPTH_W + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Entries are cleared so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= wr_ptr_reg + FIFO_DEPTH_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + FIFO_DEPTH_W'(1);
      end
      count_reg <= count_next;
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == FULL_COUNT);
  assign count     = count_reg;

endmodule

// File: rtl/data_memory_responder.sv
// Memory unit back end: executes loads/stores against data_ram, queues load
// results for the CDB and holds one word for the output port.
module data_memory_responder
  import fcpu_pkg::*;
#(
  parameter int MEM_DEPTH_W = 10
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                i_valid,
  input  logic [INSTR_W-1:0]  i_opcode,
  input  logic [RSV_ID_W-1:0] i_rsv_id,
  input  logic [DATA_W-1:0]   i_address,
  input  logic [DATA_W-1:0]   i_data,
  output logic                i_ready,
  output logic [CDB_W-1:0]    o_cdb,
  output logic                o_cdb_valid,
  input  logic                o_cdb_ready,
  output logic                o_out_valid,
  output logic [DATA_W-1:0]   o_out_data,
  input  logic                o_out_ready
);

  localparam int FIFO_DEPTH_W = 1;

  mem_op_class_t            op_class;
  logic                     accept;
  logic [MEM_DEPTH_W-1:0]   mem_index;
  logic                     ram_we;
  logic                     ram_re;
  logic [DATA_W-1:0]        ram_rdata;

  logic                     load_in_flight_reg;
  logic [RSV_ID_W-1:0]      load_rsv_reg;

  cdb_resp_t                push_resp;
  logic [CDB_W-1:0]         fifo_head;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [FIFO_DEPTH_W:0]    fifo_count;
  logic [FIFO_DEPTH_W+1:0]  occupancy;
  logic                     cdb_pop;

  logic                     out_valid_reg;
  logic                     out_valid_next;
  logic [DATA_W-1:0]        out_data_reg;
  logic [DATA_W-1:0]        out_data_next;

  logic                     unused_bits;

  assign op_class  = classify_mem_op(i_opcode);
  assign accept    = i_valid & i_ready;
  assign mem_index = i_address[MEM_DEPTH_W-1:0];
  assign ram_we    = accept & (op_class == OP_STORE);
  assign ram_re    = accept & (op_class == OP_LOAD);

  // Upper address bits alias onto the array; full flag is implied by occupancy.
  assign unused_bits = ^{i_address[DATA_W-1:MEM_DEPTH_W], fifo_full};

  data_ram #(
    .ADDR_W (MEM_DEPTH_W),
    .WIDTH  (DATA_W)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (mem_index),
    .wdata (i_data),
    .rdata (ram_rdata)
  );

  // The read issued at the accept edge returns one edge later, tagged here.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      load_in_flight_reg <= 1'b0;
      load_rsv_reg       <= '0;
    end else begin
      load_in_flight_reg <= ram_re;
      if (ram_re) begin
        load_rsv_reg <= i_rsv_id;
      end
    end
  end

  assign push_resp = '{rob_id: load_rsv_reg, data: ram_rdata};
  assign cdb_pop   = o_cdb_valid & o_cdb_ready;

  fifo #(
    .WIDTH        ($bits(cdb_resp_t)),
    .FIFO_DEPTH_W (FIFO_DEPTH_W)
  ) u_resp_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (load_in_flight_reg),
    .push_data (push_resp),
    .pop       (cdb_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign o_cdb       = fifo_head;
  assign o_cdb_valid = ~fifo_empty;

  // Count the in-flight read as occupied so a FIFO slot is always reserved.
  assign occupancy = {1'b0, fifo_count} + (FIFO_DEPTH_W + 2)'(load_in_flight_reg);
  assign i_ready   = nrst
                   & (occupancy < (FIFO_DEPTH_W + 2)'(2))
                   & ~(out_valid_reg & ~o_out_ready);

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    if (accept && (op_class == OP_OUTPUT)) begin
      out_valid_next = 1'b1;
      out_data_next  = i_data;
    end else if (o_out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign o_out_valid = out_valid_reg;
  assign o_out_data  = out_data_reg;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed and randomized checks of data_memory_responder against a
// word-array memory model with queues of expected CDB results and output words.
module tb_data_memory_responder;
  import fcpu_pkg::*;

  localparam int MEM_DEPTH_W = 10;
  localparam int MEM_DEPTH   = 1 << MEM_DEPTH_W;

  logic                clk;
  logic                nrst;
  logic                i_valid;
  logic [INSTR_W-1:0]  i_opcode;
  logic [RSV_ID_W-1:0] i_rsv_id;
  logic [DATA_W-1:0]   i_address;
  logic [DATA_W-1:0]   i_data;
  logic                i_ready;
  logic [CDB_W-1:0]    o_cdb;
  logic                o_cdb_valid;
  logic                o_cdb_ready;
  logic                o_out_valid;
  logic [DATA_W-1:0]   o_out_data;
  logic                o_out_ready;

  data_memory_responder #(.MEM_DEPTH_W(MEM_DEPTH_W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_valid     (i_valid),
    .i_opcode    (i_opcode),
    .i_rsv_id    (i_rsv_id),
    .i_address   (i_address),
    .i_data      (i_data),
    .i_ready     (i_ready),
    .o_cdb       (o_cdb),
    .o_cdb_valid (o_cdb_valid),
    .o_cdb_ready (o_cdb_ready),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .o_out_ready (o_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_rdy = 1'b0;

  logic [DATA_W-1:0] mem_m [MEM_DEPTH];
  logic [CDB_W-1:0]  exp_q [$];
  logic [DATA_W-1:0] out_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rand_readies();
    if (rand_rdy) begin
      o_cdb_ready = 1'($urandom_range(0, 1));
      o_out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle();
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rand_readies();
  endtask

  // Present one request, wait (bounded) for acceptance, then apply it to the model.
  task automatic send(input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] rsv,
                      input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data,
                      output bit acc);
    int waited;
    waited    = 0;
    acc       = 1'b0;
    i_valid   = 1'b1;
    i_opcode  = op;
    i_rsv_id  = rsv;
    i_address = addr;
    i_data    = data;
    forever begin
      @(negedge clk);
      if (i_ready) begin
        acc = 1'b1;
        break;
      end
      waited++;
      if (waited > 200) begin
        chk("req_accept_timeout", i_ready, 1);
        break;
      end
      @(posedge clk);
      #1;
      rand_readies();
    end
    @(posedge clk);
    if (acc) begin
      case (op)
        I_LOAD, I_LOADB, I_LOADTB:
          exp_q.push_back({rsv, mem_m[int'(addr) % MEM_DEPTH]});
        I_STORE, I_STOREB, I_STORER, I_STORET, I_STORETB:
          mem_m[int'(addr) % MEM_DEPTH] = data;
        I_OUTPUT:
          out_q.push_back(data);
        default: ;
      endcase
      $display("[TB] req op=%0d rsv=%0d addr=0x%0h data=0x%0h", op, rsv, addr, data);
    end
    #1;
    i_valid = 1'b0;
    rand_readies();
  endtask

  // Scoreboards: every CDB / output transfer must match the model, in order.
  always @(negedge clk) begin
    if (nrst && o_cdb_valid && o_cdb_ready) begin
      chk("cdb_result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        chk("cdb_result", o_cdb, exp_q.pop_front());
      end
    end
    if (nrst && o_out_valid && o_out_ready) begin
      chk("out_word_expected", out_q.size() > 0, 1);
      if (out_q.size() > 0) begin
        chk("out_word", o_out_data, out_q.pop_front());
      end
    end
  end

  initial begin
    bit acc;
    logic [DATA_W-1:0] addr;
    logic [INSTR_W-1:0] op;
    int r;

    nrst = 1'b1;
    i_valid = 1'b0; i_opcode = '0; i_rsv_id = '0; i_address = '0; i_data = '0;
    o_cdb_ready = 1'b1; o_out_ready = 1'b1;
    #1 nrst = 1'b0;
    #3;
    chk("rst_cdb_valid", o_cdb_valid, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_cdb", o_cdb, 0);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_i_ready", i_ready, 0);
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    #1 chk("post_rst_i_ready", i_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      send(I_STORE, 4'(i), 16'(i), 16'($urandom), acc);
    end

    // Store then load at the next edge; result exactly two edges after accept.
    send(I_STORE, 4'd3, 16'd5, 16'h1234, acc);
    send(I_LOAD, 4'd7, 16'd5, 16'h0, acc);
    @(negedge clk);
    chk("lat_edge1_valid", o_cdb_valid, 0);
    @(negedge clk);
    chk("lat_edge2_valid", o_cdb_valid, 1);
    chk("lat_edge2_cdb", o_cdb, {4'd7, 16'h1234});
    @(posedge clk); #1;

    send(I_STORE, 4'd0, 16'h0405, 16'h00AA, acc);
    send(I_LOAD, 4'd6, 16'h0005, 16'h0, acc);
    @(negedge clk); @(negedge clk);
    chk("alias_valid", o_cdb_valid, 1);
    chk("alias_data", o_cdb[DATA_W-1:0], 16'h00AA);
    @(posedge clk); #1;

    // Back-pressure: third load must wait until the CDB drains.
    o_cdb_ready = 1'b0;
    send(I_LOAD, 4'd1, 16'd1, 16'h0, acc);
    send(I_LOAD, 4'd2, 16'd2, 16'h0, acc);
    i_valid = 1'b1; i_opcode = I_LOAD; i_rsv_id = 4'd3; i_address = 16'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_i_ready", i_ready, 0);
      chk("bp_head_rsv", o_cdb[CDB_W-1:DATA_W], 1);
      chk("bp_valid", o_cdb_valid, 1);
      @(posedge clk); #1;
    end
    o_cdb_ready = 1'b1;
    send(I_LOAD, 4'd3, 16'd3, 16'h0, acc);
    chk("bp_third_accepted", acc, 1);
    repeat (4) idle();
    chk("bp_drained", exp_q.size(), 0);

    // Output port stall and release.
    o_out_ready = 1'b0;
    send(I_OUTPUT, 4'd0, 16'd0, 16'h0041, acc);
    @(negedge clk);
    chk("out_valid_held", o_out_valid, 1);
    chk("out_data_held", o_out_data, 16'h0041);
    chk("out_stall_i_ready", i_ready, 0);
    @(posedge clk); #1;
    o_out_ready = 1'b1;
    @(negedge clk);
    chk("out_release_i_ready", i_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("out_cleared", o_out_valid, 0);
    chk("out_after_i_ready", i_ready, 1);
    @(posedge clk); #1;

    // Random in-order stream with random back-pressure and aliased addresses.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      addr = 16'((32'($urandom_range(0, 63)) << 10) | 32'($urandom_range(0, 15)));
      if (r < 40) begin
        case ($urandom_range(0, 2))
          0: op = I_LOAD;
          1: op = I_LOADB;
          default: op = I_LOADTB;
        endcase
      end else if (r < 75) begin
        case ($urandom_range(0, 4))
          0: op = I_STORE;
          1: op = I_STOREB;
          2: op = I_STORER;
          3: op = I_STORET;
          default: op = I_STORETB;
        endcase
      end else if (r < 88) begin
        op = I_OUTPUT;
      end else begin
        case ($urandom_range(0, 2))
          0: op = I_ADD;
          1: op = I_NOP;
          default: op = I_JMP;
        endcase
      end
      send(op, 4'($urandom_range(0, 15)), addr, 16'($urandom), acc);
      if ($urandom_range(0, 3) == 0) idle();
    end
    rand_rdy = 1'b0;
    o_cdb_ready = 1'b1;
    o_out_ready = 1'b1;
    repeat (8) idle();
    chk("rand_cdb_drained", exp_q.size(), 0);
    chk("rand_out_drained", out_q.size(), 0);

    // Reset with a result already queued, then with a read still in flight.
    for (int v = 0; v < 2; v++) begin
      o_cdb_ready = 1'b0;
      send(I_LOAD, 4'(9 + v), 16'd5, 16'h0, acc);
      if (v == 0) begin
        @(posedge clk);
        #2 chk("rst_mid_valid_before", o_cdb_valid, 1);
      end else begin
        #2;
      end
      nrst = 1'b0;
      #1;
      chk("rst_mid_cdb_valid", o_cdb_valid, 0);
      chk("rst_mid_cdb", o_cdb, 0);
      chk("rst_mid_i_ready", i_ready, 0);
      exp_q.delete();
      @(negedge clk); @(negedge clk);
      nrst = 1'b1;
      #1 chk("rst_mid_release_i_ready", i_ready, 1);
      o_cdb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("rst_mid_no_response", o_cdb_valid, 0);
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
